// File: rtl/ram_pkg.sv
// Purpose: shared types, constants and parameter legality check for ram_sp_pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int READ_LAT_MAX = 2;
    localparam int BYTE_W       = 8;

    // Evaluated at elaboration; a false result stops the build in ram_sp_pipe.
    function automatic bit params_ok(input int data_w, input int addr_w,
                                     input int depth, input int read_lat);
        return (data_w > 0) && ((data_w % BYTE_W) == 0) &&
               (addr_w > 0) && (addr_w < 31) &&
               (depth > 0) && (depth <= (1 << addr_w)) &&
               (read_lat >= 0) && (read_lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Purpose: bare single-port word array with byte-lane writes.
// Latency: read data combinational when READ_LAT=0, one edge otherwise.
// Backpressure: none; one operation per cycle, caller guarantees address range.
// Ports: clka; wr_en_i/wr_be_i/wdata_i write side; rd_en_i read strobe;
//        addr_i shared word address; rdata_o read data.
module ram_sp_core
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int READ_LAT = 1
) (
    input  logic                       clka,
    input  logic                       wr_en_i,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       rd_en_i,
    input  logic [ADDR_W-1:0]          addr_i,
    output logic [DATA_W-1:0]          rdata_o
);
    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clka) begin
        if (wr_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_comb_rd
            // Gate with the strobe so an idle or out-of-range cycle reads as zero.
            assign rdata_o = rd_en_i ? mem_q[addr_i] : '0;
        end else begin : g_reg_rd
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge clka) begin
                if (rd_en_i) begin
                    rdata_q <= mem_q[addr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/ram_sp_pipe.sv
// Purpose: single-port RAM with valid/ready request port, range check and clear engine.
// Latency: read response READ_LAT (0..2) edges after acceptance, one per cycle in order.
// Backpressure: req_ready low while clearing or when clr_start is high; responses cannot stall.
// Ports: clka/rsta; req_* request (valid/ready, we, be, addr, wdata);
//        rsp_* read response (valid, rdata, err); err_flag sticky range error;
//        clr_start/clr_busy clear engine control and status.
module ram_sp_pipe
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int READ_LAT = 1
) (
    input  logic                       clka,
    input  logic                       rsta,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [DATA_W/BYTE_W-1:0]   req_be,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       err_flag,
    input  logic                       clr_start,
    output logic                       clr_busy
);
    localparam int                NB      = DATA_W / BYTE_W;
    localparam bit                PARAMS_OK = params_ok(DATA_W, ADDR_W, DEPTH, READ_LAT);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("ram_sp_pipe: illegal DATA_W/ADDR_W/DEPTH/READ_LAT combination");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              err_q, err_d;

    logic              clearing, acc, rd_acc, in_range;
    logic [DATA_W-1:0] core_rdata;

    logic              fin_vld, fin_err;
    logic [DATA_W-1:0] fin_dat;
    logic [DATA_W-1:0] last_q;

    assign clearing  = (state_q == CLEAR);
    // rsta term keeps ready low during reset even though state is already IDLE.
    assign req_ready = (state_q == IDLE) & ~clr_start & ~rsta;
    assign acc       = req_valid & req_ready;
    assign rd_acc    = acc & ~req_we;
    assign in_range  = ({1'b0, req_addr} < DEPTH_X);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    err_d     = 1'b0;
                end else if (acc && !in_range) begin
                    err_d = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    // The clear engine owns the array port while running; requests are blocked then.
    ram_sp_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT)
    ) u_core (
        .clka    (clka),
        .wr_en_i (clearing | (acc & req_we & in_range)),
        .wr_be_i (clearing ? {NB{1'b1}} : req_be),
        .wdata_i (clearing ? '0 : req_wdata),
        .rd_en_i (rd_acc & in_range),
        .addr_i  (clearing ? clr_cnt_q : req_addr),
        .rdata_o (core_rdata)
    );

    generate
        if (READ_LAT == 0) begin : g_lat0
            // Core already returns zero for out-of-range reads (strobe gated).
            assign fin_vld = rd_acc;
            assign fin_err = ~in_range;
            assign fin_dat = core_rdata;
        end else begin : g_latn
            logic              v1_q, e1_q;
            logic [DATA_W-1:0] s1_dat;

            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) begin
                    v1_q <= 1'b0;
                    e1_q <= 1'b0;
                end else begin
                    v1_q <= rd_acc;
                    e1_q <= rd_acc & ~in_range;
                end
            end
            // Core register is not loaded for out-of-range reads, so mask here.
            assign s1_dat = e1_q ? '0 : core_rdata;

            if (READ_LAT == 1) begin : g_lat1
                assign fin_vld = v1_q;
                assign fin_err = e1_q;
                assign fin_dat = s1_dat;
            end else begin : g_lat2
                logic              v2_q, e2_q;
                logic [DATA_W-1:0] d2_q;
                always_ff @(posedge clka or posedge rsta) begin
                    if (rsta) begin
                        v2_q <= 1'b0;
                        e2_q <= 1'b0;
                        d2_q <= '0;
                    end else begin
                        v2_q <= v1_q;
                        e2_q <= e1_q;
                        if (v1_q) begin
                            d2_q <= s1_dat;
                        end
                    end
                end
                assign fin_vld = v2_q;
                assign fin_err = e2_q;
                assign fin_dat = d2_q;
            end
        end
    endgenerate

    // Remember the last delivered word so rsp_rdata is stable between responses.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            last_q <= '0;
        end else if (fin_vld) begin
            last_q <= fin_dat;
        end
    end

    assign rsp_valid = fin_vld;
    assign rsp_err   = fin_vld & fin_err;
    assign rsp_rdata = fin_vld ? fin_dat : last_q;
    assign err_flag  = err_q;
    assign clr_busy  = clearing;

endmodule

// File: tb/tb_ram_sp_pipe.sv
module tb_ram_sp_pipe;

    localparam int AW = 10;
    localparam int ND = 3;

    logic          clka = 1'b0;
    logic          rsta = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [3:0]    req_be = '0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          clr_start = 1'b0;

    logic        rdy [ND];
    logic        rv  [ND];
    logic        re  [ND];
    logic        ef  [ND];
    logic        cb  [ND];
    logic [31:0] rd  [ND];

    always #5 clka = ~clka;

    ram_sp_pipe #(.DATA_W(32), .ADDR_W(AW), .DEPTH(300), .READ_LAT(0)) u_l0 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]), .err_flag(ef[0]),
        .clr_start(clr_start), .clr_busy(cb[0]));

    ram_sp_pipe #(.DATA_W(32), .ADDR_W(AW), .DEPTH(512), .READ_LAT(1)) u_l1 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]), .err_flag(ef[1]),
        .clr_start(clr_start), .clr_busy(cb[1]));

    ram_sp_pipe #(.DATA_W(32), .ADDR_W(AW), .DEPTH(300), .READ_LAT(2)) u_l2 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]), .err_flag(ef[2]),
        .clr_start(clr_start), .clr_busy(cb[2]));

    function automatic int dep(input int i);
        return (i == 1) ? 512 : 300;
    endfunction

    function automatic int lat(input int i);
        return i;
    endfunction

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sbq [ND][$];
    logic [31:0] mem_m  [ND][1024];
    bit          busy_m [ND];
    int          cidx_m [ND];
    bit          err_m  [ND];
    logic [31:0] last_m [ND];
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    exp_t        mon_e;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic step(input logic v, input logic we, input logic [3:0] be,
                        input int a, input logic [31:0] d, input logic clr);
        bit   acc [ND];
        exp_t e;
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = a[AW-1:0];
        req_wdata = d;
        clr_start = clr;
        #1;
        for (int i = 0; i < ND; i++) begin
            acc[i] = v && !busy_m[i] && !clr;
            chk_eq($sformatf("req_ready[%0d]", i), rdy[i], !busy_m[i] && !clr);
            chk_eq($sformatf("clr_busy[%0d]", i), cb[i], busy_m[i]);
            chk_eq($sformatf("err_flag[%0d]", i), ef[i], err_m[i]);
            if (acc[i] && !we) begin
                e.err = (a >= dep(i));
                e.dat = e.err ? 32'h0 : mem_m[i][a];
                e.due = cyc + lat(i);
                sbq[i].push_back(e);
            end
        end
        @(posedge clka);
        cyc++;
        for (int i = 0; i < ND; i++) begin
            if (acc[i] && we) begin
                if (a < dep(i)) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem_m[i][a][b*8 +: 8] = d[b*8 +: 8];
                end else begin
                    err_m[i] = 1'b1;
                end
            end
            if (acc[i] && !we && a >= dep(i)) err_m[i] = 1'b1;
            if (busy_m[i]) begin
                mem_m[i][cidx_m[i]] = 32'h0;
                cidx_m[i]++;
                if (cidx_m[i] == dep(i)) busy_m[i] = 1'b0;
            end else if (clr) begin
                busy_m[i] = 1'b1;
                cidx_m[i] = 0;
                err_m[i]  = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b0);
    endtask

    // Asserts reset at once (callable mid-clear), checks outputs, releases at posedge+1.
    task automatic do_reset();
        mon_en    = 1'b0;
        rsta      = 1'b1;
        req_valid = 1'b0;
        clr_start = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            chk_eq($sformatf("rst_ready[%0d]", i), rdy[i], 0);
            chk_eq($sformatf("rst_rsp_valid[%0d]", i), rv[i], 0);
            chk_eq($sformatf("rst_rdata[%0d]", i), rd[i], 0);
            chk_eq($sformatf("rst_rsp_err[%0d]", i), re[i], 0);
            chk_eq($sformatf("rst_err_flag[%0d]", i), ef[i], 0);
            chk_eq($sformatf("rst_clr_busy[%0d]", i), cb[i], 0);
            sbq[i].delete();
            busy_m[i] = 1'b0;
            cidx_m[i] = 0;
            err_m[i]  = 1'b0;
            last_m[i] = 32'h0;
        end
        repeat (2) @(posedge clka);
        #1;
        rsta   = 1'b0;
        mon_en = 1'b1;
    endtask

    // Response scoreboard, sampled on the falling edge.
    always @(negedge clka) begin
        if (mon_en && !rsta) begin
            for (int i = 0; i < ND; i++) begin
                if (rv[i] === 1'b1) begin
                    if (sbq[i].size() == 0) begin
                        chk_eq($sformatf("unexpected_rsp[%0d]", i), rv[i], 0);
                    end else begin
                        mon_e = sbq[i].pop_front();
                        chk_eq($sformatf("rsp_rdata[%0d]", i), rd[i], mon_e.dat);
                        chk_eq($sformatf("rsp_err[%0d]", i), re[i], mon_e.err);
                        chk_eq($sformatf("rsp_cycle[%0d]", i), cyc, mon_e.due);
                        last_m[i] = mon_e.dat;
                    end
                end else begin
                    chk_eq($sformatf("hold_rdata[%0d]", i), rd[i], last_m[i]);
                    chk_eq($sformatf("idle_rsp_err[%0d]", i), re[i], 0);
                    if (sbq[i].size() != 0 && sbq[i][0].due <= cyc) begin
                        chk_eq($sformatf("missing_rsp[%0d]", i), rv[i], 1);
                        void'(sbq[i].pop_front());
                    end
                end
            end
        end
    end

    int bcnt;

    initial begin
        @(posedge clka);
        #1;
        do_reset();

        // Byte lanes: merged word must come back.
        step(1, 1, 4'hF, 5, 32'hDEADBEEF, 0);
        step(1, 1, 4'h1, 5, 32'h000000AA, 0);
        step(1, 0, 4'h0, 5, 32'h0, 0);
        step(1, 1, 4'h0, 5, 32'h12345678, 0);   // all-zero be: no-op
        step(1, 0, 4'h0, 5, 32'h0, 0);
        idle(3);

        // Back-to-back reads after fill with addr*3.
        for (int a = 0; a < 8; a++) step(1, 1, 4'hF, a, 32'(a * 3), 0);
        for (int a = 0; a < 8; a++) step(1, 0, 4'h0, a, 32'h0, 0);
        idle(4);

        // Range checks: 600 out for all, 400 out only for DEPTH=300 instances.
        step(1, 1, 4'hF, 600, 32'hBAD0BAD0, 0);
        step(1, 1, 4'hF, 400, 32'h0000C400, 0);
        step(1, 1, 4'hF, 299, 32'h00000299, 0);
        step(1, 0, 4'h0, 600, 32'h0, 0);
        step(1, 0, 4'h0, 400, 32'h0, 0);
        step(1, 0, 4'h0, 299, 32'h0, 0);
        idle(4);

        // Fill, then a read the cycle before clr_start, then clr_start with a read.
        for (int a = 0; a < 512; a++) step(1, 1, 4'hF, a, 32'hFFFFFFFF, 0);
        step(1, 0, 4'h0, 10, 32'h0, 0);
        step(1, 0, 4'h0, 11, 32'h0, 1);
        bcnt = 0;
        for (int n = 0; n < 520; n++) begin
            if (cb[1] === 1'b1) bcnt++;
            idle(1);
        end
        chk_eq("clr_busy_cycles", bcnt, 512);
        step(1, 0, 4'h0, 0, 32'h0, 0);
        step(1, 0, 4'h0, 255, 32'h0, 0);
        step(1, 0, 4'h0, 511, 32'h0, 0);
        idle(4);

        // Reset about 100 cycles into a clear.
        for (int a = 0; a < 512; a++) step(1, 1, 4'hF, a, 32'hFFFFFFFF, 0);
        step(0, 0, 4'h0, 0, 32'h0, 1);
        idle(100);
        do_reset();
        step(1, 0, 4'h0, 50, 32'h0, 0);
        step(1, 0, 4'h0, 200, 32'h0, 0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
